// File: rtl/serial_mant_subtractor.sv
// -----------------------------------------------------------------------------
// serial_mant_subtractor
//
// Bit-serial mantissa subtractor for the floating-point add/subtract datapath.
// Produces |a - b| and the sign of a - b, LSB first, one bit per clock, using a
// single borrow flip-flop. When a < b the raw difference is negated with a
// second serial pass (two's complement) before being published.
//
// Latency from the edge that accepts start to the first cycle with done=1:
//    W edges when a >= b, 2W edges when a < b.
//
// Optional build macro: SERIAL_SUB_LZC_EN
//    Adds the lzc output, the leading-zero count of the published diff.
//
// Ports:
//    clk    in   system clock, rising edge
//    rst    in   asynchronous active-high reset
//    start  in   request, only looked at while idle
//    a      in   [W] minuend mantissa, sampled on the accepting edge
//    b      in   [W] subtrahend mantissa, sampled on the accepting edge
//    busy   out  high in every state except IDLE
//    done   out  one-cycle pulse, result valid
//    diff   out  [W] magnitude |a - b|, held until the next result
//    neg    out  1 when a < b, held with diff
//    zero   out  1 when a == b, held with diff
//    lzc    out  [$clog2(W+1)] leading zeros of diff (SERIAL_SUB_LZC_EN only)
// -----------------------------------------------------------------------------
module serial_mant_subtractor #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         neg,
   output logic         zero
`ifdef SERIAL_SUB_LZC_EN
   ,
   output logic [$clog2(W+1)-1:0] lzc
`endif
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      NEG,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res;
   logic          borrow;
   logic          seen_one;
   logic [CW-1:0] count;

   logic          last_bit;
   logic          sub_bit;
   logic          borrow_nxt;
   logic          neg_bit;
   logic [W-1:0]  sub_shift;
   logic [W-1:0]  neg_shift;
   logic [W-1:0]  final_mag;
   logic          result_we;

`ifdef SERIAL_SUB_LZC_EN
   localparam int LW = $clog2(W + 1);

   // Leading-zero count scanning from the MSB; an all-zero word yields W.
   function automatic logic [LW-1:0] lead_zeros(input logic [W-1:0] v);
      logic [LW-1:0] cnt;
      logic          found;
      cnt   = '0;
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      cnt   = cnt + LW'(1);
         end
      end
      return cnt;
   endfunction
`endif

   assign last_bit = (count == CW'(W - 1));

   // Serial bit cells. The subtract cell consumes the LSBs of the operand
   // shift registers; the negate cell walks the raw result, passing bits
   // unchanged up to and including the first 1 and inverting every bit after
   // it. Both shift the new bit in from the MSB side so that after W steps
   // the result register holds the word in its natural bit order. final_mag
   // is the word that will be published on the edge entering DONE.
   always_comb begin
      sub_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
      borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
      sub_shift  = {sub_bit, res[W-1:1]};
      neg_bit    = res[0] ^ seen_one;
      neg_shift  = {neg_bit, res[W-1:1]};
      final_mag  = (state == NEG) ? neg_shift : sub_shift;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and handshake outputs. A final borrow out of the
   // subtract pass means a < b, so the raw difference is a two's complement
   // negative and needs the extra negate pass. start is ignored outside IDLE.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SUB;
         end
         SUB: begin
            if (last_bit) state_nxt = borrow_nxt ? NEG : DONE;
         end
         NEG: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The published result is written only on the edge that enters DONE, so
   // the previous result stays visible for the whole busy period.
   assign result_we = (state_nxt == DONE) && (state != DONE);

   // Serial datapath. The borrow flop is left untouched during NEG so that it
   // still records the sign when the result is published. The counter is
   // cleared at the end of SUB so NEG can reuse it for its own W bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res      <= '0;
         borrow   <= 1'b0;
         seen_one <= 1'b0;
         count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow   <= 1'b0;
                  seen_one <= 1'b0;
                  count    <= '0;
               end
            end
            SUB: begin
               a_sh     <= a_sh >> 1;
               b_sh     <= b_sh >> 1;
               borrow   <= borrow_nxt;
               res      <= sub_shift;
               seen_one <= 1'b0;
               count    <= last_bit ? '0 : count + CW'(1);
            end
            NEG: begin
               res      <= neg_shift;
               seen_one <= seen_one | res[0];
               count    <= last_bit ? '0 : count + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Published result registers. neg is taken from the state being left:
   // only the negate pass can lead into DONE with a < b.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff <= '0;
         neg  <= 1'b0;
         zero <= 1'b0;
`ifdef SERIAL_SUB_LZC_EN
         lzc  <= '0;
`endif
      end else if (result_we) begin
         diff <= final_mag;
         neg  <= (state == NEG);
         zero <= (final_mag == '0);
`ifdef SERIAL_SUB_LZC_EN
         lzc  <= lead_zeros(final_mag);
`endif
      end
   end

endmodule

// File: tb/tb_serial_mant_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_mant_subtractor
//
// Self-checking bench for serial_mant_subtractor at W=8. A table of directed
// vectors with hand-computed results is run back to back, followed by
// hand-written sequences for start-while-busy and reset during the negate
// pass. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_mant_subtractor;

   localparam int W     = 8;
   localparam int LIMIT = 4 * W + 10;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         neg;
   logic         zero;
`ifdef SERIAL_SUB_LZC_EN
   logic [3:0]   lzc;
`endif

   int checks   = 0;
   int failures = 0;

   // Bench's own record of the last published magnitude, used to check
   // that diff is held while a new operation is in flight.
   logic [W-1:0] exp_prev_diff;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         neg;
      logic         zero;
      int           lat;
      int           lzc;
   } vec_t;

   vec_t vecs[8];

   serial_mant_subtractor #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .neg   (neg),
      .zero  (zero)
`ifdef SERIAL_SUB_LZC_EN
      ,
      .lzc   (lzc)
`endif
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its required value and log mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Pulse start with the given operands, scramble the inputs while busy,
   // and wait (bounded) for done. lat counts rising edges after the
   // accepting edge; -1 means done never arrived.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output int lat);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = ~av;
      b     = bv ^ 8'h55;
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      checkOutput("diff_held_busy", {24'd0, diff}, {24'd0, exp_prev_diff});
      lat = 0;
      while (!done && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   initial begin
      int lat;
      int pulses;

      vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0,  8, 3};
      vecs[1] = '{8'h3C, 8'h5A, 8'h1E, 1'b1, 1'b0, 16, 3};
      vecs[2] = '{8'h77, 8'h77, 8'h00, 1'b0, 1'b1,  8, 8};
      vecs[3] = '{8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 16, 0};
      vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0,  8, 0};
      vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0,  8, 1};
      vecs[6] = '{8'h01, 8'h80, 8'h7F, 1'b1, 1'b0, 16, 1};
      vecs[7] = '{8'h02, 8'h01, 8'h01, 1'b0, 1'b0,  8, 7};

      rst           = 1'b1;
      start         = 1'b0;
      a             = '0;
      b             = '0;
      exp_prev_diff = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_diff", {24'd0, diff}, 32'd0);
      checkOutput("reset_neg",  {31'd0, neg},  32'd0);
      checkOutput("reset_zero", {31'd0, zero}, 32'd0);
`ifdef SERIAL_SUB_LZC_EN
      checkOutput("reset_lzc",  {28'd0, lzc},  32'd0);
`endif
      rst = 1'b0;

      // Table-driven vectors, issued back to back.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat);
         checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         checkOutput($sformatf("v%0d_diff", i), {24'd0, diff}, {24'd0, vecs[i].diff});
         checkOutput($sformatf("v%0d_neg", i), {31'd0, neg}, {31'd0, vecs[i].neg});
         checkOutput($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
`ifdef SERIAL_SUB_LZC_EN
         checkOutput($sformatf("v%0d_lzc", i), {28'd0, lzc}, vecs[i].lzc);
`endif
         exp_prev_diff = vecs[i].diff;
         @(negedge clk);
         checkOutput($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
         checkOutput($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
      end

      // start while busy is ignored and the operands may change mid-run.
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 8'h33;
      b     = 8'h44;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checkOutput("busy_start_pulses", pulses, 1);
      checkOutput("busy_start_diff", {24'd0, diff}, 32'h7F);
      checkOutput("busy_start_neg", {31'd0, neg}, 32'd0);
      exp_prev_diff = 8'h7F;

      // Asynchronous reset during the negate pass.
      @(negedge clk);
      a     = 8'h3C;
      b     = 8'h5A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      checkOutput("neg_pass_busy", {31'd0, busy}, 32'd1);
      checkOutput("neg_pass_diff_held", {24'd0, diff}, 32'h7F);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_rst_done", {31'd0, done}, 32'd0);
      checkOutput("async_rst_diff", {24'd0, diff}, 32'd0);
      checkOutput("async_rst_neg",  {31'd0, neg},  32'd0);
      checkOutput("async_rst_zero", {31'd0, zero}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checkOutput("after_rst_no_done", pulses, 0);
      exp_prev_diff = '0;

      applyStimulus(8'h02, 8'h01, lat);
      checkOutput("restart_latency", lat, 8);
      checkOutput("restart_diff", {24'd0, diff}, 32'h01);
      checkOutput("restart_neg", {31'd0, neg}, 32'd0);
      checkOutput("restart_zero", {31'd0, zero}, 32'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_mant_subtractor.md
Name: serial_mant_subtractor

Overview:
- Bit-serial mantissa subtractor for the floating-point add/subtract datapath; performs the reverse operation of the adder cell chain.
- Computes |A−B| and the sign of A−B, LSB-first, one bit per clock, using a single borrow flip-flop.
- Sits between exponent alignment (supplies aligned mantissas) and normalization (consumes magnitude, sign, zero flag).
- Start/done handshake; operands sampled once, result held until next start.

Parameters:
- W, 24, mantissa width in bits (including hidden bit); minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  minuend mantissa, sampled on the accepting edge.
- b  input  W  subtrahend mantissa, sampled on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  W  magnitude |a−b|; held until next accepted start.
- neg  output  1  1 when a < b (unsigned); held with diff.
- zero  output  1  1 when a == b; held with diff.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, diff=0, neg=0, zero=0; borrow and bit counter cleared. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - start=1 → latch a, b; borrow=0; count=0; go to SUB.
  - diff, neg, and zero keep their previous values until a new result is written.
- SUB: one bit per edge, LSB first.
  - d_i = a_i ^ b_i ^ br.
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into the result register from the MSB side.
  - After bit W−1: final borrow=0 → DONE with neg=0; final borrow=1 → NEG with neg=1 and count reset.
- NEG: serial two's complement of the result, LSB first, one bit per edge.
  - Output bit = r_i ^ seen_one; seen_one is set after the first 1 bit is passed.
  - After W bits → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - diff, neg, and zero are updated on the edge entering DONE.
  - zero = (diff == 0).
  - Next edge → IDLE.
- Latency, counted from the edge that samples start to the first cycle with done=1: W edges when a ≥ b, 2W edges when a < b.
- Result registers update only on entry to DONE. During busy, diff, neg, and zero show the previous result.
- start while busy (SUB, NEG, DONE) is ignored; no queuing. start in the cycle after done is accepted normally.
- The a and b inputs may change freely while busy.
- Boundary cases:
  - a=b gives diff=0, neg=0, zero=1, latency W.
  - a=0, b=2^W−1 gives diff=2^W−1, neg=1.
  - neg=1 is never reported with zero=1.

Optional Feature:
- Macro: SERIAL_SUB_LZC_EN.
- When defined:
  - Adds output lzc, width $clog2(W+1): the leading-zero count of the final diff.
  - lzc is written on the same edge as diff; lzc=W when zero=1; reset value 0.
  - Computed combinationally from the final magnitude at DONE entry. Latency is unchanged.
- When undefined: no lzc port and no added logic; all other behaviour identical.

Test Plan:
- W=8, a=0x5A, b=0x3C, pulse start → done after 8 edges; diff=0x1E, neg=0, zero=0; busy high for 8 cycles plus the DONE cycle.
- W=8, a=0x3C, b=0x5A → done after 16 edges; diff=0x1E, neg=1, zero=0.
- W=8, a=0x77, b=0x77 → done after 8 edges; diff=0x00, neg=0, zero=1. Then a=0x00, b=0xFF → diff=0xFF, neg=1 after 16 edges.
- W=8, start a=0x80, b=0x01; pulse start with a=0x10, b=0x01 during SUB; change a and b mid-operation → exactly one done pulse, diff=0x7F; second start ignored.
- W=8, start a=0x3C, b=0x5A; assert rst during NEG → all outputs 0 immediately (asynchronous), no done. Restart a=0x02, b=0x01 → diff=0x01 after 8 edges.
- With SERIAL_SUB_LZC_EN defined, W=8: 0x5A−0x3C gives lzc=3; 0x77−0x77 gives lzc=8; 0x00−0xFF gives lzc=0.
